// File: rtl/reset_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default timing constants and a small elaboration-time helper.
package reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam int DEFAULT_DELAY_CYCLES   = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one independent chain per bit, cleared by the
// asynchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_async[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_sync = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all domains in reset, then frees them one by
// one, waiting for each domain's (synchronized) ack before spacing out the next.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int DELAY_CYCLES   = DEFAULT_DELAY_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_ready,
  output logic                  busy,
  output logic                  fault,
  output logic [IDX_W-1:0]      fault_stage
);

  localparam int CNT_W = $clog2(max_int(DELAY_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  // The ack-acceptance edge is the first spacing cycle, so DELAY itself
  // lasts one cycle less than DELAY_CYCLES.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((DELAY_CYCLES > 1) ? DELAY_CYCLES - 2 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  logic [NUM_STAGES-1:0] w_ack_sync;
  logic [IDX_W-1:0]      w_drop_idx;
  logic [IDX_W-1:0]      w_idx_inc;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic [NUM_STAGES-1:0] r_rst_out;
  logic [NUM_STAGES-1:0] w_rst_out_next;
  logic                  r_all_ready;
  logic                  w_all_ready_next;
  logic                  r_busy;
  logic                  w_busy_next;
  logic                  r_fault;
  logic                  w_fault_next;
  logic [IDX_W-1:0]      r_fault_stage;
  logic [IDX_W-1:0]      w_fault_stage_next;

  sync_2ff #(
    .WIDTH (NUM_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (stage_ack),
    .o_sync  (w_ack_sync)
  );

  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_drop_idx = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (!w_ack_sync[k]) w_drop_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_HOLD;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_rst_out     <= '1;
      r_all_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_fault       <= 1'b0;
      r_fault_stage <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_rst_out     <= w_rst_out_next;
      r_all_ready   <= w_all_ready_next;
      r_busy        <= w_busy_next;
      r_fault       <= w_fault_next;
      r_fault_stage <= w_fault_stage_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_idx_next         = r_idx;
    w_rst_out_next     = r_rst_out;
    w_fault_next       = r_fault;
    w_fault_stage_next = r_fault_stage;

    if (soft_rst_req) begin
      w_state_next       = ST_HOLD;
      w_cnt_next         = '0;
      w_idx_next         = '0;
      w_rst_out_next     = '1;
      w_fault_next       = 1'b0;
      w_fault_stage_next = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_rst_out_next = '1;
          if (r_cnt == HOLD_LAST) begin
            w_rst_out_next[0] = 1'b0;
            w_idx_next        = '0;
            w_cnt_next        = '0;
            w_state_next      = ST_WAIT_ACK;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_DELAY: begin
          if (r_cnt == GAP_LAST) begin
            w_rst_out_next[r_idx] = 1'b0;
            w_cnt_next            = '0;
            w_state_next          = ST_WAIT_ACK;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_WAIT_ACK: begin
          if (w_ack_sync[r_idx]) begin
            w_cnt_next = '0;
            if (r_idx == LAST_IDX) begin
              w_state_next = ST_DONE;
            end else if (DELAY_CYCLES == 1) begin
              w_idx_next                = w_idx_inc;
              w_rst_out_next[w_idx_inc] = 1'b0;
            end else begin
              w_idx_next   = w_idx_inc;
              w_state_next = ST_DELAY;
            end
          end else if (r_cnt == TO_LAST) begin
            w_state_next       = ST_FAULT;
            w_rst_out_next     = '1;
            w_fault_next       = 1'b1;
            w_fault_stage_next = r_idx;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (!(&w_ack_sync)) begin
            w_state_next       = ST_FAULT;
            w_rst_out_next     = '1;
            w_fault_next       = 1'b1;
            w_fault_stage_next = w_drop_idx;
          end
        end

        ST_FAULT: begin
          w_rst_out_next = '1;
          w_fault_next   = 1'b1;
        end

        default: begin
          w_state_next   = ST_HOLD;
          w_cnt_next     = '0;
          w_idx_next     = '0;
          w_rst_out_next = '1;
        end
      endcase
    end

    w_all_ready_next = (w_state_next == ST_DONE);
    w_busy_next      = (w_state_next == ST_HOLD) || (w_state_next == ST_DELAY) ||
                       (w_state_next == ST_WAIT_ACK);
  end

  assign rst_out     = r_rst_out;
  assign all_ready   = r_all_ready;
  assign busy        = r_busy;
  assign fault       = r_fault;
  assign fault_stage = r_fault_stage;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of sequenced reset domains (2..8).
REQ-002 Parameter DELAY_CYCLES, default 16: hold/spacing cycles before each stage release (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for a stage ack (>=4).
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 Port: clk, input, 1, sole clock.
REQ-006 Port: rst, input, 1, asynchronous active-high reset, already synchronized on deassertion upstream.
REQ-007 Port: soft_rst_req, input, 1, synchronous single-cycle restart request.
REQ-008 Port: stage_ack, input, NUM_STAGES, asynchronous per-stage ready (PLL lock, config done), level.
REQ-009 Port: rst_out, output, NUM_STAGES, active-high reset to each downstream domain.
REQ-010 Port: all_ready, output, 1, high when all stages are released and acked.
REQ-011 Port: busy, output, 1, high while sequencing.
REQ-012 Port: fault, output, 1, sticky timeout/ack-loss flag.
REQ-013 Port: fault_stage, output, max(1,$clog2(NUM_STAGES)), index of the faulting stage.

Function
REQ-014 stage_ack SHALL pass through a 2-flop synchronizer per bit; all ack decisions use the synchronized value (+2 cycles latency).
REQ-015 FSM states SHALL be: HOLD, DELAY, WAIT_ACK, DONE, FAULT.
REQ-016 HOLD: all rst_out=1; count DELAY_CYCLES rising edges with rst low; on the last one deassert rst_out[0], set stage index i=0, enter WAIT_ACK.
REQ-017 WAIT_ACK: on synced ack[i]=1, if i=NUM_STAGES-1 enter DONE, else i<=i+1 and enter DELAY; counter clears on entry.
REQ-018 DELAY: after DELAY_CYCLES cycles deassert rst_out[i], enter WAIT_ACK.
REQ-019 Timeout: if WAIT_ACK spends TIMEOUT_CYCLES cycles without ack, enter FAULT with fault_stage=i.
REQ-020 DONE: all_ready=1; any synced ack falling SHALL enter FAULT with fault_stage=lowest dropped index.
REQ-021 FAULT: all rst_out=1, fault=1, all_ready=0; state held until soft_rst_req or rst.
REQ-022 Release order: rst_out[k] SHALL deassert only after all j<k are deasserted and acked; reassertion is always all stages in the same cycle.
REQ-023 soft_rst_req=1 in any state SHALL on the next edge set all rst_out=1, clear fault/fault_stage/counters, enter HOLD; it wins over a simultaneous ack or timeout.
REQ-024 An ack for stage >i, or an ack already high on entry to WAIT_ACK, SHALL be accepted without error (ack on entry advances on the first WAIT_ACK cycle).
REQ-025 busy=1 in HOLD, DELAY, WAIT_ACK; 0 in DONE and FAULT.
REQ-026 Counter width SHALL be $clog2(max(DELAY_CYCLES,TIMEOUT_CYCLES)+1); no wrap in any state.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL asynchronously force rst_out=all ones, all_ready=0, busy=1, fault=0, fault_stage=0, state HOLD, counter 0, synchronizer flops 0.
REQ-029 rst asserted mid-sequence SHALL reassert all rst_out immediately, without waiting for a clock edge.

Structure
REQ-030 FSM state enum and the default DELAY/TIMEOUT constants SHALL reside in the shared package reset_pkg.
REQ-031 One sub-module, sync_2ff (parameterized width), SHALL implement the ack synchronizer.

Verification (NUM_STAGES=3, DELAY_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-032 Nominal: release rst, each ack rises 3 cycles after its rst_out falls -> rst_out[0] falls at edge 4, stages fall in order 0,1,2 spaced by ack+2+4 cycles, then all_ready=1, busy=0.
REQ-033 Timeout: ack[1] never rises -> fault=1, fault_stage=1, rst_out=3'b111 exactly 16 cycles after WAIT_ACK entry for stage 1.
REQ-034 Ack loss: in DONE drop ack[2] and ack[0] together -> FAULT with fault_stage=0, all rst_out=1 within 3 cycles.
REQ-035 soft_rst_req in the same cycle as the final ack -> HOLD entered, all_ready stays 0, sequence restarts from stage 0.
REQ-036 rst pulse mid-DELAY, off clock edge -> rst_out=3'b111 asynchronously, full sequence repeats after deassertion.
REQ-037 Acks tied high from time 0 -> stages release every 4 cycles (+2-cycle sync latency on first), no fault.
